// File: rtl/chart_pkg.sv
// Shared types and constants for the chart player: FSM states, lane bit
// positions within a chart word, and the default end-of-chart marker.
package chart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } chart_state_e;

  localparam int LANE_L = 0;
  localparam int LANE_D = 1;
  localparam int LANE_U = 2;
  localparam int LANE_R = 3;

  localparam logic [7:0] END_MARKER = 8'hFF;

endpackage

// File: rtl/beat_counter.sv
// Free-running divider: counts 0..beat_div_p-1 while enabled and flags the
// last count combinationally so the owner can act in the same cycle.
module beat_counter #(
  parameter int beat_div_p = 3000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int cw_lp = $clog2(beat_div_p);
  localparam logic [cw_lp-1:0] last_lp = cw_lp'(beat_div_p - 1);

  logic [cw_lp-1:0] count_q;

  assign tick_o = en_i && (count_q == last_lp);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= tick_o ? '0 : count_q + cw_lp'(1);
    end
  end

endmodule

// File: rtl/chart_sequencer.sv
// Steps through the chart ROM one word per beat and hands arrow notes to the
// scroller; also reports beat, done and a sticky overrun flag.
module chart_sequencer
  import chart_pkg::*;
#(
  parameter int                 width_p      = 8,
  parameter int                 depth_p      = 128,
  parameter int                 lanes_p      = 4,
  parameter int                 beat_div_p   = 3000000,
  parameter logic [width_p-1:0] end_marker_p = width_p'(END_MARKER),
  parameter bit                 loop_p       = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       pause_i,
  output logic [$clog2(depth_p)-1:0] rd_addr_o,
  input  logic [width_p-1:0]         rd_data_i,
  output logic [lanes_p-1:0]         note_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       beat_o,
  output logic                       playing_o,
  output logic                       done_o,
  output logic                       overrun_o,
  output chart_state_e               state_o
);

  localparam int aw_lp = $clog2(depth_p);
  localparam logic [aw_lp-1:0] last_addr_lp = aw_lp'(depth_p - 1);

  chart_state_e       state_q, state_d;
  logic [aw_lp-1:0]   addr_q, addr_d;
  logic [lanes_p-1:0] note_q, note_d;
  logic [lanes_p-1:0] mask;
  logic               valid_q, valid_d;
  logic               beat_q, beat_d;
  logic               overrun_q, overrun_d;
  logic               tick;
  logic               count_clear;
  logic               count_en;

  assign mask        = rd_data_i[lanes_p-1:0];
  assign count_en    = (state_q == PLAY) && !pause_i;
  assign count_clear = stop_i || (state_q != PLAY);

  beat_counter #(
    .beat_div_p(beat_div_p)
  ) u_beat (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(count_clear),
    .en_i   (count_en),
    .tick_o (tick)
  );

  // Handshake: a note transfers on any cycle with valid_o && ready_i. Once
  // raised, note_o/valid_o hold until transfer, except that a new note
  // loaded by a tick replaces the pending one (flagged as overrun).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    note_d    = note_q;
    valid_d   = valid_q;
    beat_d    = 1'b0;
    overrun_d = overrun_q;

    if (valid_q && ready_i) valid_d = 1'b0;

    if (stop_i) begin
      state_d = IDLE;
      addr_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_d   = PLAY;
            addr_d    = '0;
            overrun_d = 1'b0;
          end
        end
        PLAY: begin
          if (tick) begin
            beat_d = 1'b1;
            if (rd_data_i == end_marker_p) begin
              if (loop_p) addr_d = '0;
              else        state_d = DONE;
            end else begin
              if (mask != '0) begin
                note_d  = mask;
                valid_d = 1'b1;
                if (valid_q && !ready_i) overrun_d = 1'b1;
              end
              // The last ROM slot ends the chart rather than wrapping.
              if (addr_q == last_addr_lp) begin
                if (loop_p) addr_d = '0;
                else        state_d = DONE;
              end else begin
                addr_d = addr_q + aw_lp'(1);
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      note_q    <= '0;
      valid_q   <= 1'b0;
      beat_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      valid_q   <= valid_d;
      beat_q    <= beat_d;
      overrun_q <= overrun_d;
    end
  end

  assign rd_addr_o = addr_q;
  assign note_o    = note_q;
  assign valid_o   = valid_q;
  assign beat_o    = beat_q;
  assign overrun_o = overrun_q;
  assign playing_o = (state_q == PLAY);
  assign done_o    = (state_q == DONE);
  assign state_o   = state_q;

endmodule

// File: doc/chart_sequencer.md
Name: chart_sequencer

Overview:
- Plays a step chart out of the chart ROM: drives the ROM read address, samples one chart word per chart step, and emits arrow notes to the downstream note scroller over a valid/ready handshake.
- Sits between the chart ROM (combinational read) and the scroller/judge logic.
- Also produces a one-cycle beat pulse, a done flag and a sticky overrun flag.

Parameters:
- width_p, 8: ROM word width.
- depth_p, 128: ROM depth; address width is $clog2(depth_p).
- lanes_p, 4: arrow lanes. Note mask is rd_data_i[lanes_p-1:0], bit0=L, bit1=D, bit2=U, bit3=R.
- beat_div_p, 3000000: clocks per chart step. Must be >= 2.
- end_marker_p, 8'hFF: chart word that terminates the chart.
- loop_p, 0: 1 = restart at address 0 on chart end instead of stopping.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin playback (level, sampled each cycle)
- stop_i  in  1  abort playback
- pause_i  in  1  freeze the step counter while high
- rd_addr_o  out  $clog2(depth_p)  chart ROM address
- rd_data_i  in  width_p  chart ROM data, combinational from rd_addr_o
- note_o  out  lanes_p  arrow mask of the pending note
- valid_o  out  1  note_o is valid
- ready_i  in  1  downstream accepts the note
- beat_o  out  1  one-cycle pulse per chart step
- playing_o  out  1  state == PLAY
- done_o  out  1  state == DONE
- overrun_o  out  1  sticky: a note was overwritten before it was accepted

Behaviour:
- Reset (async assert, sync deassert by clk_i): state IDLE, rd_addr_o=0, step counter=0, note_o=0, valid_o=0, beat_o=0, overrun_o=0, playing_o=0, done_o=0.
- States:
  - IDLE: start_i -> PLAY; counter=0, addr=0, overrun cleared.
  - PLAY: stepping, see below.
  - DONE: holds; start_i -> PLAY, same init as from IDLE.
- stop_i in any state -> IDLE, addr=0, counter=0, valid_o=0. stop_i has priority over start_i and over a tick in the same cycle.
- Step counter in PLAY: counts 0..beat_div_p-1 and wraps. It holds while pause_i=1.
  - tick = (counter==beat_div_p-1) && !pause_i.
  - beat_o=1 in the cycle after a tick.
- On tick, sample rd_data_i at the current rd_addr_o:
  - Word == end_marker_p: no note emitted.
    - loop_p=1: addr<=0, stay in PLAY.
    - loop_p=0: -> DONE, addr holds.
  - Word is not the end marker but lane mask == 0: rest, no emission, addr+1.
  - Lane mask != 0: note_o<=mask, valid_o<=1, addr+1.
    - If valid_o=1 && ready_i=0 in the tick cycle, the old note is overwritten and overrun_o<=1.
  - Tick at addr==depth_p-1 with a non-marker word: process the word, then treat as chart end (loop -> addr 0, otherwise DONE). The address never wraps silently.
- Handshake:
  - Transfer occurs when valid_o && ready_i.
  - Accepted note: valid_o<=0 next cycle unless a new note loads in the same cycle; the new note wins and valid_o stays 1.
  - note_o and valid_o are stable while valid_o=1 and there is no tick.
  - A pending note survives the PLAY->DONE transition; DONE still accepts it.
- Latency: tick in cycle T -> note_o/valid_o/beat_o visible in T+1; rd_addr_o updates in T+1.
- Reset mid-playback drops any pending note immediately. overrun_o clears only on reset or on start.

Decomposition:
- Package chart_pkg holds:
  - state enum chart_state_e {IDLE, PLAY, DONE};
  - lane bit index constants LANE_L/D/U/R;
  - default END_MARKER constant.
- Sub-module beat_counter (parameter beat_div_p; ports clk_i, reset_i, clear_i, en_i, tick_o) is reused by the metronome/LED logic.

Test Plan (beat_div_p=4, depth_p=8, ROM = 01,00,0C,02,FF,...):
- Reset, start_i=1 one cycle -> first tick 4 cycles after entering PLAY; note_o=4'h1, valid_o=1 next cycle; beat_o pulses every 4 cycles; rests (word 00) emit nothing.
- ready_i=1 constantly -> notes 1, C, 2 each accepted exactly once, then done_o=1, playing_o=0, rd_addr_o=4; with loop_p=1, addr returns to 0 and note 1 repeats.
- ready_i=0 throughout -> note 1 is overwritten by C; overrun_o=1 and stays 1; note_o=C.
- pause_i=1 for 10 cycles mid-play -> no tick and no beat_o during pause; the step resumes with the remaining counter count.
- stop_i asserted with valid_o=1 and same-cycle start_i -> IDLE, valid_o=0, rd_addr_o=0.
- ROM with no FF, 8 nonzero words -> after the word at addr 7, DONE (loop_p=0); async reset_i pulse mid-play clears all outputs without waiting for a clock edge.
